// File: rtl/share_rnd_loader.sv
// Frames a K-bit word stream into an N-share Boolean vector plus RANDNUM refresh words
// for the full-XOR unmasking stage, double-buffered so outputs hold for a whole frame.
//
// state    | meaning
// LOAD_SHR | collecting share words (cnt < N_SHARES)
// LOAD_RND | collecting refresh words (cnt >= N_SHARES)
// DISCARD  | dropping words of a bad frame until s_last is accepted
module share_rnd_loader #(
  parameter int K_WIDTH  = 32,
  parameter int N_SHARES = 8,
  parameter int RANDNUM  = 12,
  localparam int MASKWIDTH = K_WIDTH * N_SHARES,
  localparam int RND_W     = (RANDNUM > 0) ? K_WIDTH * RANDNUM : K_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [K_WIDTH-1:0]   s_data,
  input  logic                 s_valid,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic [MASKWIDTH-1:0] o_x,
  output logic [RND_W-1:0]     o_rnd,
  output logic                 o_dvld,
  output logic                 o_err
);

  localparam int TOTAL = N_SHARES + RANDNUM;
  localparam int CNT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int STG_N = (TOTAL > 1) ? TOTAL - 1 : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] SHR_END  = CNT_W'(N_SHARES - 1);

  typedef enum logic [1:0] {
    LOAD_SHR = 2'd0,
    LOAD_RND = 2'd1,
    DISCARD  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [K_WIDTH-1:0] stg_q [STG_N];
  logic               accept;
  logic               stg_we;
  logic               commit;
  logic               frm_err;
  logic               dvld_q;
  logic               err_q;
  logic [K_WIDTH*TOTAL-1:0] frame_vec;

  // rst_n in the ready term keeps s_ready low for the whole time reset is asserted
  assign s_ready = ena & rst_n;
  assign accept  = s_valid & s_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stg_we  = 1'b0;
    commit  = 1'b0;
    frm_err = 1'b0;
    if (accept) begin
      case (state_q)
        LOAD_SHR, LOAD_RND: begin
          if (cnt_q == LAST_IDX) begin
            cnt_d = '0;
            if (s_last) begin
              commit  = 1'b1;
              state_d = LOAD_SHR;
            end else begin
              frm_err = 1'b1;
              state_d = DISCARD;
            end
          end else if (s_last) begin
            frm_err = 1'b1;
            cnt_d   = '0;
            state_d = LOAD_SHR;
          end else begin
            stg_we = 1'b1;
            cnt_d  = cnt_q + 1'b1;
            if (state_q == LOAD_SHR && cnt_q == SHR_END) state_d = LOAD_RND;
          end
        end
        DISCARD: begin
          if (s_last) begin
            cnt_d   = '0;
            state_d = LOAD_SHR;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = LOAD_SHR;
        end
      endcase
    end
  end

  // Final word bypasses staging so the commit happens on its own handshake edge
  always_comb begin
    frame_vec = '0;
    for (int i = 0; i < TOTAL - 1; i++) frame_vec[i*K_WIDTH +: K_WIDTH] = stg_q[i];
    frame_vec[(TOTAL-1)*K_WIDTH +: K_WIDTH] = s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD_SHR;
      cnt_q   <= '0;
      o_x     <= '0;
      dvld_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < STG_N; i++) stg_q[i] <= '0;
    end else begin
      dvld_q <= commit;
      err_q  <= frm_err;
      if (ena) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        for (int i = 0; i < STG_N; i++) begin
          if (stg_we && cnt_q == CNT_W'(i)) stg_q[i] <= s_data;
        end
        if (commit) o_x <= frame_vec[MASKWIDTH-1:0];
      end
    end
  end

  generate
    if (RANDNUM > 0) begin : g_rnd
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          o_rnd <= '0;
        end else if (ena && commit) begin
          o_rnd <= frame_vec[MASKWIDTH +: RND_W];
        end
      end
    end else begin : g_no_rnd
      assign o_rnd = '0;
    end
  endgenerate

  // Pulses are masked, not held, while ena is low; commit itself needs ena high
  assign o_dvld = dvld_q & ena;
  assign o_err  = err_q & ena;

endmodule

// File: tb/tb_share_rnd_loader.sv
// Directed bench for share_rnd_loader: expected frames and error pulses are queued when
// stimulus is driven and checked against o_dvld / o_err as they appear.
module tb_share_rnd_loader;

  localparam int K = 32;
  localparam int N = 8;
  localparam int R = 12;
  localparam int T = N + R;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           ena = 1'b0;
  logic [K-1:0]   s_data = '0;
  logic           s_valid = 1'b0;
  logic           s_last = 1'b0;
  logic           s_ready;
  logic [K*N-1:0] o_x;
  logic [K*R-1:0] o_rnd;
  logic           o_dvld;
  logic           o_err;

  share_rnd_loader #(.K_WIDTH(K), .N_SHARES(N), .RANDNUM(R)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .o_x(o_x), .o_rnd(o_rnd), .o_dvld(o_dvld), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [K*N-1:0] x;
    logic [K*R-1:0] rnd;
    int             cyc;
  } exp_t;

  exp_t exp_q[$];
  int   err_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  bit   mon_en = 1'b0;
  logic [K*N-1:0] held_x = '0;
  logic [K*R-1:0] held_rnd = '0;
  exp_t mon_e;
  int   mon_c;

  task automatic chk(input string tag, input logic [383:0] got, input logic [383:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_mis++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [K-1:0] d, input logic l);
    s_data  = d;
    s_last  = l;
    s_valid = 1'b1;
    ena     = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic push_frame(input logic [K-1:0] base);
    exp_t e;
    for (int k = 0; k < N; k++) e.x[k*K +: K] = base + K'(k);
    for (int j = 0; j < R; j++) e.rnd[j*K +: K] = base + K'(N + j);
    e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input logic [K-1:0] base);
    for (int k = 0; k < T; k++) send(base + K'(k), (k == T - 1));
    push_frame(base);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("dvld_err_exclusive", {383'b0, o_dvld & o_err}, 384'b0);
      if (o_dvld) begin
        n_cmp++;
        assert (exp_q.size() > 0) else begin
          n_mis++;
          $error("FAIL dvld_unexpected: got pulse at cycle %0d expected none", cyc);
        end
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("dvld_cycle", 384'(cyc), 384'(mon_e.cyc));
          chk("o_x", 384'(o_x), 384'(mon_e.x));
          chk("o_rnd", o_rnd, mon_e.rnd);
          held_x   = mon_e.x;
          held_rnd = mon_e.rnd;
        end
      end else begin
        chk("hold_x", 384'(o_x), 384'(held_x));
        chk("hold_rnd", o_rnd, held_rnd);
      end
      if (o_err) begin
        n_cmp++;
        assert (err_q.size() > 0) else begin
          n_mis++;
          $error("FAIL err_unexpected: got pulse at cycle %0d expected none", cyc);
        end
        if (err_q.size() > 0) begin
          mon_c = err_q.pop_front();
          chk("err_cycle", 384'(cyc), 384'(mon_c));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish by 200000 expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [K-1:0] xr_got;
    logic [K-1:0] xr_exp;

    // reset state
    rst_n = 1'b0;
    ena   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_x", 384'(o_x), 384'b0);
    chk("rst_rnd", o_rnd, 384'b0);
    chk("rst_dvld", 384'(o_dvld), 384'b0);
    chk("rst_err", 384'(o_err), 384'b0);
    chk("rst_ready", 384'(s_ready), 384'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", 384'(s_ready), 384'd1);
    mon_en = 1'b1;

    // T1 single frame
    send_frame(32'h100);
    repeat (3) @(posedge clk);
    #1;

    // T2 back-to-back frames
    send_frame(32'h800);
    send_frame(32'h900);
    repeat (3) @(posedge clk);
    #1;

    // T3 early s_last, then good frame
    for (int k = 0; k < 5; k++) send(32'h50 + K'(k), 1'b0);
    send(32'hDEAD, 1'b1);
    err_q.push_back(cyc);
    send_frame(32'hA0);
    chk("t3_x0", 384'(o_x[K-1:0]), 384'h0A0);
    repeat (2) @(posedge clk);
    #1;

    // T4 missing s_last, discard tail, then good frame
    for (int k = 0; k < T; k++) send(32'h200 + K'(k), 1'b0);
    err_q.push_back(cyc);
    send(32'h7770, 1'b0);
    send(32'h7771, 1'b0);
    send(32'h7772, 1'b1);
    send_frame(32'h300);
    repeat (2) @(posedge clk);
    #1;

    // T5 ena low mid-frame and on the final word
    for (int k = 0; k < 7; k++) send(32'h400 + K'(k), 1'b0);
    ena = 1'b0; s_valid = 1'b1; s_data = 32'hBAD; s_last = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      chk("t5_ready_mid", 384'(s_ready), 384'b0);
    end
    for (int k = 7; k < T - 1; k++) send(32'h400 + K'(k), 1'b0);
    ena = 1'b0; s_valid = 1'b1; s_data = 32'h400 + K'(T - 1); s_last = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      chk("t5_ready_final", 384'(s_ready), 384'b0);
    end
    send(32'h400 + K'(T - 1), 1'b1);
    push_frame(32'h400);
    repeat (2) @(posedge clk);
    #1;

    // T6 asynchronous reset mid-frame, then fresh frame and XOR loopback
    for (int k = 0; k < 10; k++) send(32'h500 + K'(k), 1'b0);
    #2;
    rst_n    = 1'b0;
    held_x   = '0;
    held_rnd = '0;
    #1;
    chk("t6_rst_x", 384'(o_x), 384'b0);
    chk("t6_rst_rnd", o_rnd, 384'b0);
    chk("t6_rst_ready", 384'(s_ready), 384'b0);
    chk("t6_rst_dvld", 384'(o_dvld), 384'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_frame(32'h600);
    xr_got = '0;
    xr_exp = '0;
    for (int i = 0; i < N; i++) begin
      xr_got = xr_got ^ o_x[i*K +: K];
      xr_exp = xr_exp ^ (32'h600 + K'(i));
    end
    chk("t6_xor_unmask", 384'(xr_got), 384'(xr_exp));

    repeat (4) @(posedge clk);
    #1;
    chk("pending_frames", 384'(exp_q.size()), 384'b0);
    chk("pending_errors", 384'(err_q.size()), 384'b0);
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
